// File: rtl/exe_div_sequencer.sv
// Execute-stage sequencer for the multi-cycle divider: issues the start pulse,
// stalls the front end while the divider runs and holds the result for MEM.
module exe_div_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 5,
  parameter int TIMEOUT      = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    e_valid_i,
  input  logic [ALU_OP_WIDTH-1:0] e_ALU_op_i,
  input  logic                    flush_i,
  input  logic                    m_ready_i,
  input  logic                    div_busy_i,
  input  logic [DATA_WIDTH-1:0]   div_result_i,
  output logic                    div_start_o,
  output logic                    e_stall_o,
  output logic                    e_bubble_o,
  output logic                    hold_sel_o,
  output logic [DATA_WIDTH-1:0]   hold_result_o,
  output logic                    err_o,
  output logic [CNT_WIDTH-1:0]    div_cnt_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [7:0]           WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] wait_cnt_r;
  logic       req_s;
  logic       capture_s;
  logic       abort_s;
  logic       unused_op_bits_s;

  // Divide class is funct3 100..111 of the M extension, i.e. op[4] & op[2].
  assign req_s            = e_valid_i & e_ALU_op_i[4] & e_ALU_op_i[2] & ~flush_i;
  assign unused_op_bits_s = ^{e_ALU_op_i[3], e_ALU_op_i[1:0]};

  // Next-state and pipeline control decode.
  always_comb begin
    next_state_s = state_r;
    e_stall_o    = 1'b0;
    e_bubble_o   = 1'b0;
    hold_sel_o   = 1'b0;
    capture_s    = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          e_stall_o    = 1'b1;
          e_bubble_o   = 1'b1;
          next_state_s = START;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        e_stall_o  = 1'b1;
        e_bubble_o = 1'b1;
        if (flush_i) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = WAIT;
        end
      end
      WAIT: begin
        e_stall_o  = 1'b1;
        e_bubble_o = 1'b1;
        if (flush_i) begin
          // A divider that is already idle needs no draining.
          next_state_s = div_busy_i ? DRAIN : IDLE;
        end else if (!div_busy_i) begin
          capture_s    = 1'b1;
          next_state_s = DONE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          abort_s      = 1'b1;
          next_state_s = DRAIN;
        end else begin
          next_state_s = WAIT;
        end
      end
      DONE: begin
        if (flush_i) begin
          next_state_s = IDLE;
        end else begin
          hold_sel_o   = 1'b1;
          e_stall_o    = ~m_ready_i;
          next_state_s = m_ready_i ? IDLE : DONE;
        end
      end
      DRAIN: begin
        e_stall_o    = 1'b1;
        e_bubble_o   = 1'b1;
        next_state_s = div_busy_i ? DRAIN : IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, start pulse, wait counter, captured result, error flag and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      div_start_o   <= 1'b0;
      wait_cnt_r    <= 8'd0;
      hold_result_o <= {DATA_WIDTH{1'b0}};
      err_o         <= 1'b0;
      div_cnt_o     <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= next_state_s;
      div_start_o <= (next_state_s == START);
      if (state_r == START) begin
        wait_cnt_r <= 8'd0;
      end else if (state_r == WAIT) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (capture_s) begin
        hold_result_o <= div_result_i;
      end else begin
        hold_result_o <= hold_result_o;
      end
      if (capture_s && (div_cnt_o != CNT_MAX)) begin
        div_cnt_o <= div_cnt_o + CNT_WIDTH'(1);
      end else begin
        div_cnt_o <= div_cnt_o;
      end
      if (abort_s) begin
        err_o <= 1'b1;
      end else begin
        err_o <= err_o;
      end
    end
  end

endmodule

// File: doc/exe_div_sequencer.md
Name: exe_div_sequencer

Overview:
- Controls the multi-cycle divide/remainder unit in the execute stage.
- Detects DIV/DIVU/REM/REMU in EXE, issues a one-cycle start pulse, and stalls fetch/decode/exe until the quotient or remainder is ready.
- Injects bubbles into MEM while waiting, holds the result until MEM accepts it, and handles flushes that arrive while the divider is still running.
- Sits beside the EXE stage; MUL ops (single-cycle) pass through untouched.

Parameters:
- DATA_WIDTH, 32, result width.
- ALU_OP_WIDTH, 5, ALU opcode width.
- TIMEOUT, 64, max cycles in WAIT before error abort (legal range 2..255).
- CNT_WIDTH, 16, width of completed-division counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- e_valid_i  in  1  EXE holds a valid instruction.
- e_ALU_op_i  in  ALU_OP_WIDTH  EXE opcode; divide class = op[4]&op[2] (funct3 100..111).
- flush_i  in  1  branch/jump kill of EXE instruction.
- m_ready_i  in  1  MEM stage can accept an instruction this cycle.
- div_busy_i  in  1  divider busy.
- div_result_i  in  DATA_WIDTH  divider output.
- div_start_o  out  1  start pulse to divider.
- e_stall_o  out  1  freeze PC, IF/ID and ID/EXE registers.
- e_bubble_o  out  1  force NOP into EXE/MEM register (wr enables low).
- hold_sel_o  out  1  EXE result mux selects hold_result_o instead of the live ALU output.
- hold_result_o  out  DATA_WIDTH  captured divider result.
- err_o  out  1  sticky timeout flag.
- div_cnt_o  out  CNT_WIDTH  completed-division count (saturating).

Behaviour:
- Clocking and reset:
  - Single clock. All state updates on the clk rising edge.
  - rst is synchronous, active-high.
  - On reset: state=IDLE, div_start_o=0, hold_result_o=0, err_o=0, div_cnt_o=0, wait counter=0.
  - Reset mid-operation (any state) returns to IDLE next edge. The divider's in-flight result is discarded.
- Combinational request: req = e_valid_i & op[4] & op[2] & !flush_i.
- States: IDLE, START, WAIT, DONE, DRAIN.
- IDLE:
  - If req: e_stall_o=1, e_bubble_o=1, next=START.
  - Otherwise: all control outputs 0.
- START:
  - div_start_o=1 (registered, exactly one cycle); stall=1, bubble=1.
  - div_busy_i is ignored (divider raises busy the following cycle).
  - Next=WAIT; wait counter cleared.
- WAIT:
  - stall=1, bubble=1; counter increments each cycle.
  - If div_busy_i==0: hold_result_o<=div_result_i, div_cnt_o+=1 (saturating at all-ones), next=DONE.
  - Else if counter==TIMEOUT-1: err_o<=1, next=DRAIN.
- DONE:
  - hold_sel_o=1, bubble=0, e_stall_o=!m_ready_i.
  - If m_ready_i: the instruction advances with the held result, next=IDLE.
  - A new divide in EXE the following cycle starts normally; back-to-back divides are separated by IDLE for one cycle.
- DRAIN:
  - stall=1, bubble=1.
  - Waits until div_busy_i==0, discards the result, next=IDLE.
  - Guarantees a flushed or aborted division never overlaps a new start.
- flush_i:
  - In IDLE: blocks the start.
  - In START or WAIT: next=DRAIN, no capture, no count.
  - In DONE: next=IDLE, hold_sel_o drops; result discarded, not counted as lost.
  - flush_i and completion (busy falling) in the same WAIT cycle: flush wins → IDLE (busy already low, so DRAIN is skipped); result not captured.
- err_o: cleared only by rst.
- Latency: divide of N busy cycles stalls EXE for N+2 cycles before DONE, plus any MEM back-pressure.

Test Plan:
- DIV 100/7, divider model busy 33 cycles → one div_start_o pulse; e_stall_o high 35 cycles + 1 DONE cycle (m_ready_i=1); hold_result_o=14; div_cnt_o=1; e_bubble_o low in DONE.
- MUL 6*7 (op[2]=0), then ADD → e_stall_o, div_start_o, hold_sel_o all stay 0.
- REM 100%7 with flush_i asserted in WAIT cycle 10 → DRAIN until busy low; hold_result_o unchanged; div_cnt_o unchanged; a following DIV issues a fresh div_start_o only after busy=0.
- DIV completing with m_ready_i low for 3 cycles → stays in DONE, e_stall_o=1 for 3 cycles, hold_result_o stable, then IDLE.
- Divider model never drops busy, TIMEOUT=64 → err_o=1 after 64 WAIT cycles; DRAIN held; rst pulse → err_o=0, IDLE.
- Back-to-back DIVU 0xFFFFFFFF/1 then DIVU 8/2 → two start pulses, results 0xFFFFFFFF and 4, div_cnt_o=2.
